mmio_gpio: RTL and testbench
============================

// Module: mmio_gpio
// PURPOSE
//   Memory-mapped GPIO peripheral on the Risc32 io_* bus. Parametrised successor to the fixed SW/BTN/LED decode.
//   Synchronises and debounces the switch and button inputs, latches sticky button rising edges, and adds set/clear LED writes.
//   Drives a maskable interrupt. Sits between Risc32 and board pins; read mux fully defined (no latch).
// PARAMETERS
//   BASE_ADDR        32'h0000_0000  peripheral base; selected when io_address[31:8]==BASE_ADDR[31:8]
//   SW_WIDTH         16             number of switch inputs (1..32)
//   BTN_WIDTH        5              number of button inputs (1..32)
//   LED_WIDTH        16             number of LED outputs (1..32)
//   DEBOUNCE_CYCLES  1000000        input must differ from debounced value this many consecutive cycles (>=1)
// PORTS
//   clk             in   1          system clock (CLK100MHZ at top level)
//   rst             in   1          synchronous, active-high reset
//   io_address      in   32         byte address from core
//   io_write_value  in   32         write data
//   io_write_en     in   1          write strobe, one cycle per store
//   io_read_en      in   1          read strobe
//   io_data_size    in   3          RISC-V funct3: 000 byte, 001 half, others word
//   io_read_value   out  32         read data, combinational
//   sw_in           in   SW_WIDTH   raw asynchronous switch pins
//   btn_in          in   BTN_WIDTH  raw asynchronous button pins
//   led_out         out  LED_WIDTH  LED drive (registered)
//   irq             out  1          level interrupt (registered)
// BEHAVIOUR
//   Register map, word index io_address[4:2], io_address[1:0] ignored; io_address[7:5]!=0 unmapped:
//     0 SW      RO  debounced switches, zero-extended
//     1 BTN     RO  debounced buttons
//     2 EDGE    R/W1C sticky rising-edge flags of debounced buttons
//     3 LED     RW  led register
//     4 LED_SET WO  led |= wdata; reads return LED
//     5 LED_CLR WO  led &= ~wdata; reads return LED
//     6 IRQ_EN  RW  per-button interrupt mask
//     7 -       reads 0, writes ignored
//   Write size masking: 000 -> only wdata[7:0] used (upper bits treated as 0 for LED/SET/CLR/EDGE/IRQ_EN, LED upper bits kept for LED write);
//     001 -> [15:0] likewise; else full word. Bits above the register width ignored.
//   Read: io_read_value = selected register when io_read_en && selected, else 32'h0. Zero-latency, same cycle.
//   Input path per bit: 2-flop synchroniser (s1,s2) -> debouncer (stable, cnt):
//     s2!=stable: cnt<=cnt+1; if cnt==DEBOUNCE_CYCLES-1 then stable<=s2, cnt<=0.
//     s2==stable: cnt<=0 (any bounce restarts count).
//     Pin change held steady appears in stable DEBOUNCE_CYCLES+2 rising edges after first sampling edge.
//     cnt width $clog2(DEBOUNCE_CYCLES+1).
//   EDGE[i] set on the edge where btn stable[i] goes 0->1.
//     Set and W1C of same bit in same cycle: set wins.
//   irq <= |(EDGE & IRQ_EN), one cycle after flag/mask change.
//   LED writes take effect on the write edge; led_out reflects the register directly.
//   Reset (rst high at clk edge): s1,s2,stable,cnt,EDGE,IRQ_EN,LED <= 0; led_out=0, irq=0.
//     io_read_value=0 unless read.
//     rst mid-debounce discards count.
//     Input held high through reset is re-debounced after release and sets its EDGE flag.
// TESTING  (DEBOUNCE_CYCLES=4, BASE_ADDR=0)
//   1 rst 2 cycles, btn_in=0 -> led_out=0, irq=0, read idx1/2/6 = 0, read idx7 = 0, read with io_read_en=0 = 0.
//   2 btn_in[0] 0->1 held -> BTN reads 0 for 5 edges, 32'h1 from 6th; EDGE=32'h1; with IRQ_EN=1 irq=1 next cycle.
//   3 btn_in[1] toggled 1 for 3 cycles then 0, repeated 5x -> BTN[1] never set, EDGE=0, irq stays 0.
//   4 write LED=16'h00F0; LED_SET 16'h0003; LED_CLR 16'h0010 -> led_out 00F0,00F3,00E3 on successive write edges.
//   5 write EDGE=1 in same cycle a new btn[0] rising edge stabilises -> EDGE[0] remains 1;
//     later W1C alone -> 0, irq drops next cycle.
//   6 byte write (size 000) of 32'hFFFF_FF55 to LED holding 16'hAA00 -> led_out 16'hAA55; sw_in=16'h1234 -> SW reads 32'h1234.

Source files
------------

// File: rtl/mmio_gpio.sv
// mmio_gpio
//   Memory-mapped GPIO peripheral for the Risc32 io_* bus.
//   Switch and button pins are synchronised and debounced.
//   Rising edges of the debounced buttons latch into sticky EDGE flags, which are cleared by writing 1.
//   LEDs can be written directly, or bit-set and bit-cleared through separate registers.
//   A level interrupt is raised while any enabled EDGE flag is pending.
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   io_address     byte address; the block is selected when [31:8] matches BASE_ADDR and [7:5]==0
//   io_write_value write data
//   io_write_en    write strobe (one cycle per store)
//   io_read_en     read strobe
//   io_data_size   funct3 access size: 000 byte, 001 half, others word
//   io_read_value  combinational read data, 0 when not reading this block
//   sw_in          raw switch pins
//   btn_in         raw button pins
//   led_out        registered LED drive
//   irq            registered level interrupt
//
// Register map (word index io_address[4:2])
//   0 SW (RO), 1 BTN (RO), 2 EDGE (W1C), 3 LED (RW),
//   4 LED_SET (WO, reads LED), 5 LED_CLR (WO, reads LED), 6 IRQ_EN (RW), 7 reserved
module mmio_gpio #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          SW_WIDTH        = 16,
  parameter int          BTN_WIDTH       = 5,
  parameter int          LED_WIDTH       = 16,
  parameter int          DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          io_address,
  input  logic [31:0]          io_write_value,
  input  logic                 io_write_en,
  input  logic                 io_read_en,
  input  logic [2:0]           io_data_size,
  output logic [31:0]          io_read_value,
  input  logic [SW_WIDTH-1:0]  sw_in,
  input  logic [BTN_WIDTH-1:0] btn_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 irq
);

  localparam int IN_W = SW_WIDTH + BTN_WIDTH;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    REG_SW      = 3'd0,
    REG_BTN     = 3'd1,
    REG_EDGE    = 3'd2,
    REG_LED     = 3'd3,
    REG_LED_SET = 3'd4,
    REG_LED_CLR = 3'd5,
    REG_IRQ_EN  = 3'd6,
    REG_NONE    = 3'd7
  } reg_idx_e;

  // Switches and buttons share one synchroniser/debouncer array: switches in the low bits, buttons above.
  logic [IN_W-1:0] raw, s1, s2, stable, stable_next;
  logic [CW-1:0]   cnt      [IN_W];
  logic [CW-1:0]   cnt_next [IN_W];

  logic [SW_WIDTH-1:0]  sw_db;
  logic [BTN_WIDTH-1:0] btn_db, btn_rise, edge_flags, edge_clr, irq_en;
  logic [LED_WIDTH-1:0] led;

  logic        sel, wr;
  reg_idx_e    idx;
  logic [31:0] size_mask, wdata_m;
  logic        unused_addr;

  assign raw         = {btn_in, sw_in};
  assign sw_db       = stable[SW_WIDTH-1:0];
  assign btn_db      = stable[IN_W-1:SW_WIDTH];
  assign unused_addr = ^io_address[1:0];

  // A bit only adopts the synchronised value after it has disagreed with the stable value for DEBOUNCE_CYCLES
  // consecutive cycles; any agreement in between restarts the count.
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < IN_W; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_next[i] = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rise is taken from the next stable value so that the EDGE flag is set on the same edge the button settles.
  assign btn_rise = stable_next[IN_W-1:SW_WIDTH] & ~btn_db;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < IN_W; i++) cnt[i] <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      stable <= stable_next;
      for (int i = 0; i < IN_W; i++) cnt[i] <= cnt_next[i];
    end
  end

  // Bus decode. Narrow writes zero the unused upper data bits; the LED register alone keeps its upper bits.
  always_comb begin
    sel = (io_address[31:8] == BASE_ADDR[31:8]) && (io_address[7:5] == 3'b000);
    idx = reg_idx_e'(io_address[4:2]);
    wr  = io_write_en && sel;
    case (io_data_size)
      3'b000:  size_mask = 32'h0000_00FF;
      3'b001:  size_mask = 32'h0000_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
    wdata_m  = io_write_value & size_mask;
    edge_clr = (wr && idx == REG_EDGE) ? BTN_WIDTH'(wdata_m) : '0;
  end

  // Control registers. A new rising edge is ORed in after the W1C mask, so a set wins over a clear of the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_flags <= '0;
      irq_en     <= '0;
      led        <= '0;
      irq        <= 1'b0;
    end else begin
      edge_flags <= (edge_flags & ~edge_clr) | btn_rise;
      irq        <= |(edge_flags & irq_en);
      if (wr) begin
        case (idx)
          REG_LED:     led    <= LED_WIDTH'((32'(led) & ~size_mask) | wdata_m);
          REG_LED_SET: led    <= led | LED_WIDTH'(wdata_m);
          REG_LED_CLR: led    <= led & ~LED_WIDTH'(wdata_m);
          REG_IRQ_EN:  irq_en <= BTN_WIDTH'(wdata_m);
          default:     ;
        endcase
      end
    end
  end

  assign led_out = led;

  // Read data is zero whenever the block is not being read, so the bus can OR peripherals together.
  always_comb begin
    io_read_value = 32'h0;
    if (io_read_en && sel) begin
      case (idx)
        REG_SW:      io_read_value = 32'(sw_db);
        REG_BTN:     io_read_value = 32'(btn_db);
        REG_EDGE:    io_read_value = 32'(edge_flags);
        REG_LED:     io_read_value = 32'(led);
        REG_LED_SET: io_read_value = 32'(led);
        REG_LED_CLR: io_read_value = 32'(led);
        REG_IRQ_EN:  io_read_value = 32'(irq_en);
        default:     io_read_value = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio
//   Self-checking bench for mmio_gpio with DEBOUNCE_CYCLES=4 and BASE_ADDR=0.
//   A table of bus write/read vectors exercises the LED, IRQ_EN and decode paths.
//   Hand-written sequences then cover debounce timing, bounce rejection, EDGE set-versus-clear and reset behaviour.
module tb_mmio_gpio;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] io_address;
  logic [31:0] io_write_value;
  logic        io_write_en;
  logic        io_read_en;
  logic [2:0]  io_data_size;
  logic [31:0] io_read_value;
  logic [15:0] sw_in;
  logic [4:0]  btn_in;
  logic [15:0] led_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mmio_gpio #(
    .BASE_ADDR(32'h0), .SW_WIDTH(16), .BTN_WIDTH(5), .LED_WIDTH(16), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst),
    .io_address(io_address), .io_write_value(io_write_value),
    .io_write_en(io_write_en), .io_read_en(io_read_en),
    .io_data_size(io_data_size), .io_read_value(io_read_value),
    .sw_in(sw_in), .btn_in(btn_in),
    .led_out(led_out), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    logic [31:0] expect_val;
  } vec_t;

  vec_t vecs[20];

  // Advance one rising edge, then step off it so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size);
    io_address     = addr;
    io_write_value = data;
    io_data_size   = size;
    io_write_en    = 1'b1;
    tick();
    io_write_en    = 1'b0;
    io_write_value = 32'h0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    io_address = addr;
    io_read_en = 1'b1;
    #1;
    data       = io_read_value;
    io_read_en = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] expected);
    logic [31:0] r;
    busRead(addr, r);
    checkOutput(name, r, expected);
  endtask

  task automatic applyStimulus(input int n, input vec_t v);
    logic [31:0] r;
    if (v.is_read) begin
      busRead(v.addr, r);
      checkOutput($sformatf("vec%0d read", n), r, v.expect_val);
    end else begin
      busWrite(v.addr, v.data, v.size);
      checkOutput($sformatf("vec%0d led_out", n), 32'(led_out), v.expect_val);
    end
  endtask

  initial begin
    logic [31:0] r;

    // Writes check led_out after the write edge; reads check io_read_value.
    vecs[0]  = '{1'b0, 32'h0C,  32'h0000_00F0, 3'b010, 32'h00F0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0000_0003, 3'b010, 32'h00F3};
    vecs[2]  = '{1'b0, 32'h14,  32'h0000_0010, 3'b010, 32'h00E3};
    vecs[3]  = '{1'b1, 32'h10,  32'h0,         3'b010, 32'h00E3};
    vecs[4]  = '{1'b1, 32'h16,  32'h0,         3'b010, 32'h00E3};
    vecs[5]  = '{1'b0, 32'h0C,  32'h0000_AA00, 3'b010, 32'hAA00};
    vecs[6]  = '{1'b0, 32'h0C,  32'hFFFF_FF55, 3'b000, 32'hAA55};
    vecs[7]  = '{1'b0, 32'h0D,  32'h1234_BEEF, 3'b001, 32'hBEEF};
    vecs[8]  = '{1'b0, 32'h10,  32'hFFFF_0F00, 3'b000, 32'hBEEF};
    vecs[9]  = '{1'b0, 32'h14,  32'hFFFF_00FF, 3'b001, 32'hBE00};
    vecs[10] = '{1'b0, 32'h2C,  32'hFFFF_FFFF, 3'b010, 32'hBE00};
    vecs[11] = '{1'b0, 32'h10C, 32'hFFFF_FFFF, 3'b010, 32'hBE00};
    vecs[12] = '{1'b1, 32'h2C,  32'h0,         3'b010, 32'h0};
    vecs[13] = '{1'b0, 32'h1C,  32'hFFFF_FFFF, 3'b010, 32'hBE00};
    vecs[14] = '{1'b1, 32'h1C,  32'h0,         3'b010, 32'h0};
    vecs[15] = '{1'b0, 32'h18,  32'hFFFF_FFFF, 3'b010, 32'hBE00};
    vecs[16] = '{1'b1, 32'h18,  32'h0,         3'b010, 32'h1F};
    vecs[17] = '{1'b0, 32'h18,  32'h0000_0101, 3'b000, 32'hBE00};
    vecs[18] = '{1'b1, 32'h18,  32'h0,         3'b010, 32'h01};
    vecs[19] = '{1'b1, 32'h0C,  32'h0,         3'b010, 32'hBE00};

    rst = 1'b1; io_address = 32'h0; io_write_value = 32'h0; io_write_en = 1'b0;
    io_read_en = 1'b0; io_data_size = 3'b010; sw_in = 16'h0; btn_in = 5'h0;

    // Reset state.
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset led_out", 32'(led_out), 32'h0);
    checkOutput("reset irq", 32'(irq), 32'h0);
    readCheck("reset BTN", 32'h04, 32'h0);
    readCheck("reset EDGE", 32'h08, 32'h0);
    readCheck("reset IRQ_EN", 32'h18, 32'h0);
    readCheck("reset idx7", 32'h1C, 32'h0);
    io_address = 32'h0C; io_read_en = 1'b0; #1;
    checkOutput("no read_en", io_read_value, 32'h0);

    // Register-level vectors; IRQ_EN ends as 1.
    for (int i = 0; i < 20; i++) applyStimulus(i, vecs[i]);
    checkOutput("irq idle", 32'(irq), 32'h0);

    // btn[0] rises: settles on the 6th edge, EDGE set on that edge, irq one edge later.
    btn_in[0] = 1'b1;
    for (int e = 1; e <= DB + 2; e++) begin
      tick();
      readCheck($sformatf("btn0 edge%0d", e), 32'h04, (e >= DB + 2) ? 32'h1 : 32'h0);
    end
    readCheck("btn0 EDGE", 32'h08, 32'h1);
    checkOutput("irq before", 32'(irq), 32'h0);
    tick();
    checkOutput("irq after", 32'(irq), 32'h1);

    // Clear the flag so the bounce test starts clean.
    busWrite(32'h08, 32'h1, 3'b010);
    readCheck("w1c EDGE", 32'h08, 32'h0);
    tick();
    checkOutput("w1c irq", 32'(irq), 32'h0);

    // btn[1] bounces high for only 3 cycles at a time and must never settle.
    for (int k = 0; k < 5; k++) begin
      btn_in[1] = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      btn_in[1] = 1'b0;
      for (int c = 0; c < 2; c++) tick();
      readCheck($sformatf("bounce BTN%0d", k), 32'h04, 32'h1);
    end
    for (int c = 0; c < 4; c++) tick();
    readCheck("bounce BTN final", 32'h04, 32'h1);
    readCheck("bounce EDGE", 32'h08, 32'h0);
    checkOutput("bounce irq", 32'(irq), 32'h0);

    // Release btn[0] and let it settle low.
    btn_in[0] = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    readCheck("btn0 low", 32'h04, 32'h0);

    // New rising edge settles on the same edge as a W1C of bit 0: set wins.
    btn_in[0] = 1'b1;
    for (int e = 1; e <= DB + 1; e++) tick();
    readCheck("pre-settle BTN", 32'h04, 32'h0);
    busWrite(32'h08, 32'h1, 3'b010);
    readCheck("set wins BTN", 32'h04, 32'h1);
    readCheck("set wins EDGE", 32'h08, 32'h1);
    tick();
    checkOutput("set wins irq", 32'(irq), 32'h1);
    busWrite(32'h08, 32'h1, 3'b010);
    readCheck("w1c2 EDGE", 32'h08, 32'h0);
    checkOutput("w1c2 irq same edge", 32'(irq), 32'h1);
    tick();
    checkOutput("w1c2 irq dropped", 32'(irq), 32'h0);

    // Switch path.
    sw_in = 16'h1234;
    for (int c = 0; c < DB + 1; c++) tick();
    readCheck("sw early", 32'h00, 32'h0);
    tick();
    readCheck("sw 1234", 32'h00, 32'h1234);

    // Reset with btn[0] held high: state clears, then the button re-debounces and re-flags.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkOutput("rst2 led_out", 32'(led_out), 32'h0);
    checkOutput("rst2 irq", 32'(irq), 32'h0);
    readCheck("rst2 BTN", 32'h04, 32'h0);
    readCheck("rst2 IRQ_EN", 32'h18, 32'h0);
    for (int e = 1; e <= DB + 2; e++) tick();
    readCheck("rst2 BTN settled", 32'h04, 32'h1);
    readCheck("rst2 EDGE", 32'h08, 32'h1);
    tick(); tick();
    checkOutput("rst2 irq masked", 32'(irq), 32'h0);
    busRead(32'h00, r);
    checkOutput("rst2 SW", r, 32'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
